// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// Each bit is held for CLKS_PER_BIT clk cycles; busy and uart_tx come straight from flops.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       uart_tx
);

    // A one-cycle bit period still needs a 1-bit counter so the compare is well formed.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] cycle_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_reg_next;
    logic             tx_next;
    logic             busy_next;
    logic             bit_done;

    assign bit_done = (cycle_cnt == LAST_CYCLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cycle_cnt <= cycle_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
            uart_tx   <= tx_next;
            busy      <= busy_next;
        end
    end

    // Next-state logic computes the value the line takes on the coming edge, so the
    // serial output changes exactly on each bit boundary with no input-to-output path.
    always_comb begin
        state_next     = state;
        cycle_cnt_next = cycle_cnt;
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;
        tx_next        = uart_tx;
        busy_next      = busy;

        case (state)
            IDLE: begin
                tx_next        = 1'b1;
                busy_next      = 1'b0;
                cycle_cnt_next = '0;
                bit_idx_next   = '0;
                if (start) begin
                    shift_reg_next = data;
                    state_next     = START;
                    busy_next      = 1'b1;
                    tx_next        = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    cycle_cnt_next = '0;
                    bit_idx_next   = '0;
                    tx_next        = shift_reg[0];
                    state_next     = DATA;
                end else begin
                    cycle_cnt_next = cycle_cnt + CNT_W'(1);
                end
            end

            // The shift register is consumed from the bottom, so bit 1 is always the next bit.
            DATA: begin
                if (bit_done) begin
                    cycle_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next   = bit_idx + 3'd1;
                        shift_reg_next = {1'b0, shift_reg[7:1]};
                        tx_next        = shift_reg[1];
                    end
                end else begin
                    cycle_cnt_next = cycle_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    cycle_cnt_next = '0;
                    state_next     = IDLE;
                    busy_next      = 1'b0;
                    tx_next        = 1'b1;
                end else begin
                    cycle_cnt_next = cycle_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Randomized scoreboard bench for uart_tx_8n1: a frame-level reference model predicts
// busy/line per cycle and queues expected bytes; a line monitor decodes frames and checks them.
module tb_uart_tx_8n1;

    localparam int CPB     = 4;
    localparam int FRAME_C = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       start;
    logic       busy;
    logic       uart_tx;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [7:0] exp_q[$];

    int         m_rem = 0;
    logic [9:0] m_frame = '1;
    logic       m_busy = 1'b0;
    logic       m_tx = 1'b1;

    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_bits = '0;
    int         busy_run = 0;

    uart_tx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .start   (start),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int hold);
        data  = b;
        start = 1'b1;
        tick(hold);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_rem == 0 && !mon_active) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        check_output("idle_timeout", {31'd0, done}, 32'd1);
        tick(2);
    endtask

    // Frame-level model: a frame is a 10-bit vector indexed by elapsed cycles / CPB.
    always @(posedge clk) begin
        if (reset) begin
            m_rem  = 0;
            m_busy = 1'b0;
            m_tx   = 1'b1;
            exp_q.delete();
        end else if (m_rem == 0) begin
            if (start) begin
                m_frame = {1'b1, data, 1'b0};
                m_rem   = FRAME_C;
                m_busy  = 1'b1;
                m_tx    = 1'b0;
                exp_q.push_back(data);
            end else begin
                m_busy = 1'b0;
                m_tx   = 1'b1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_tx   = 1'b1;
            end else begin
                m_tx = m_frame[(FRAME_C - m_rem) / CPB];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("busy", {31'd0, busy}, {31'd0, m_busy});
            check_output("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx});
        end
    end

    // Line monitor: samples each bit mid-period, then pops the scoreboard.
    always @(negedge clk) begin
        if (check_en) begin
            if (reset) begin
                mon_active = 1'b0;
                busy_run   = 0;
            end else begin
                if (!mon_active && uart_tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
                if (mon_active) begin
                    if (mon_cnt % CPB == CPB / 2)
                        mon_bits[mon_cnt / CPB] = uart_tx;
                    if (mon_cnt == 9 * CPB + CPB / 2) begin
                        mon_active = 1'b0;
                        check_output("start_bit", {31'd0, mon_bits[0]}, 32'd0);
                        check_output("stop_bit", {31'd0, mon_bits[9]}, 32'd1);
                        if (exp_q.size() == 0) begin
                            check_output("unexpected_frame", {24'd0, mon_bits[8:1]}, 32'hFFFF_FFFF);
                        end else begin
                            check_output("frame_data", {24'd0, mon_bits[8:1]}, {24'd0, exp_q.pop_front()});
                        end
                    end
                    mon_cnt++;
                end
                if (busy === 1'b1) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    check_output("busy_length", busy_run, FRAME_C);
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b1;
        data  = 8'($urandom);
        tick(1);
        check_en = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        tick(3);

        $display("[TB] directed frames");
        apply_stimulus(8'hAA, 1);
        wait_idle();
        apply_stimulus(8'h01, 1);
        wait_idle();
        apply_stimulus(8'h80, 1);
        wait_idle();

        $display("[TB] start held high for 100 cycles");
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data = 8'($urandom);
            tick(1);
        end
        start = 1'b0;
        wait_idle();

        $display("[TB] data and start changed mid-frame");
        apply_stimulus(8'h55, 1);
        tick(8);
        data  = 8'hFF;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        wait_idle();

        $display("[TB] reset mid-frame");
        apply_stimulus(8'hC3, 1);
        tick(14);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        apply_stimulus(8'h3C, 1);
        wait_idle();

        $display("[TB] randomized frames");
        for (int n = 0; n < 20; n++) begin
            apply_stimulus(8'($urandom), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(1, 30)));
                data  = 8'($urandom);
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            wait_idle();
            tick(int'($urandom_range(0, 4)));
        end

        check_output("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
